// File: rtl/reg_openadc_adcfifo_mc_if.sv
// USB register bus between the host-side register decoder and the
// multi-channel ADC FIFO register block.
interface reg_openadc_adcfifo_mc_if #(
  parameter int pBYTECNT_SIZE = 7
);
  logic [7:0]               reg_address;
  logic [pBYTECNT_SIZE-1:0] reg_bytecnt;
  logic [7:0]               reg_datai;
  logic [7:0]               reg_datao;
  logic                     reg_read;
  logic                     reg_write;

  modport master (
    output reg_address, reg_bytecnt, reg_datai, reg_read, reg_write,
    input  reg_datao
  );

  modport slave (
    input  reg_address, reg_bytecnt, reg_datai, reg_read, reg_write,
    output reg_datao
  );
endinterface

// File: rtl/reg_openadc_adcfifo_mc.sv
// Multi-channel OpenADC FIFO register block: status/config registers, sticky
// errors and delayed FIFO read strobes. Optional read counter: FIFO_READ_COUNT_EN.
`ifndef ADCREAD_ADDR
`define ADCREAD_ADDR 8'd3
`endif
`ifndef STREAM_SEGMENT_THRESHOLD
`define STREAM_SEGMENT_THRESHOLD 8'd35
`endif
`ifndef FAST_FIFO_READ_MODE
`define FAST_FIFO_READ_MODE 8'd36
`endif
`ifndef CAPTURE_DONE
`define CAPTURE_DONE 8'd37
`endif
`ifndef ADC_LOW_RES
`define ADC_LOW_RES 8'd38
`endif
`ifndef FIFO_STAT
`define FIFO_STAT 8'd39
`endif
`ifndef FIFO_CHAN_SEL
`define FIFO_CHAN_SEL 8'd40
`endif
`ifndef FIFO_RD_DELAY
`define FIFO_RD_DELAY 8'd41
`endif
`ifndef FIFO_STICKY_ERR
`define FIFO_STICKY_ERR 8'd42
`endif
`ifndef DEBUG_FIFO_READS
`define DEBUG_FIFO_READS 8'd43
`endif

module reg_openadc_adcfifo_mc #(
  parameter int pBYTECNT_SIZE = 7,
  parameter int pCHANNELS     = 2,
  parameter int pERR_WIDTH    = 9,
  parameter int pTHRESH_WIDTH = 17,
  parameter int pMAX_RD_DELAY = 7
) (
  input  logic                            clk_usb,
  input  logic                            reset_i,
  reg_openadc_adcfifo_mc_if.slave         bus,
  input  logic [pCHANNELS-1:0]            fifo_empty,
  input  logic [pCHANNELS*pERR_WIDTH-1:0] fifo_error_stat,
  output logic [pCHANNELS-1:0]            fifo_rd_en,
  input  logic                            capture_done,
  output logic                            low_res,
  output logic                            fast_fifo_read_mode,
  output logic [pTHRESH_WIDTH-1:0]        stream_segment_threshold,
  output logic                            clear_fifo_errors
);

  localparam logic [31:0] THRESH_RST = 32'h0001_0000;

  function automatic logic [7:0] get_byte(input logic [63:0] v,
                                          input logic [pBYTECNT_SIZE-1:0] idx);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (int'(idx) == i) r = v[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [3:0] clamp_delay(input logic [3:0] v);
    if (int'(v) > pMAX_RD_DELAY) return 4'(pMAX_RD_DELAY);
    return v;
  endfunction

  function automatic logic [pCHANNELS-1:0] chan_onehot(input logic [2:0] sel);
    logic [pCHANNELS-1:0] r;
    r = '0;
    for (int n = 0; n < pCHANNELS; n++)
      if (sel == 3'(n)) r[n] = 1'b1;
    return r;
  endfunction

  logic [7:0]               addr;
  logic [pBYTECNT_SIZE-1:0] bytecnt;
  logic [7:0]               datai;
  logic                     rd;
  logic                     wr;
  logic [7:0]               datao;

  assign addr          = bus.reg_address;
  assign bytecnt       = bus.reg_bytecnt;
  assign datai         = bus.reg_datai;
  assign rd            = bus.reg_read;
  assign wr            = bus.reg_write;
  assign bus.reg_datao = datao;

  logic [2:0]            chan_sel;
  logic [3:0]            rd_delay;
  logic [pERR_WIDTH-1:0] sticky [pCHANNELS];

  // Channel views padded to the full 3-bit select range; unused slots read 0,
  // which gives out-of-range selects their zero status for free.
  logic [7:0]            empty_pad;
  logic [pERR_WIDTH-1:0] live_pad   [8];
  logic [pERR_WIDTH-1:0] sticky_pad [8];

  for (genvar n = 0; n < 8; n++) begin : g_pad
    if (n < pCHANNELS) begin : g_used
      assign empty_pad[n]  = fifo_empty[n];
      assign live_pad[n]   = fifo_error_stat[n*pERR_WIDTH +: pERR_WIDTH];
      assign sticky_pad[n] = sticky[n];
    end else begin : g_unused
      assign empty_pad[n]  = 1'b0;
      assign live_pad[n]   = '0;
      assign sticky_pad[n] = '0;
    end
  end

  always_ff @(posedge clk_usb or posedge reset_i) begin
    if (reset_i) begin
      chan_sel                 <= '0;
      rd_delay                 <= '0;
      low_res                  <= 1'b0;
      fast_fifo_read_mode      <= 1'b0;
      stream_segment_threshold <= THRESH_RST[pTHRESH_WIDTH-1:0];
      clear_fifo_errors        <= 1'b0;
    end else begin
      clear_fifo_errors <= wr && (addr == `FIFO_STAT) && datai[0];
      if (wr) begin
        if (addr != `FAST_FIFO_READ_MODE) fast_fifo_read_mode <= 1'b0;
        case (addr)
          `FIFO_CHAN_SEL:       chan_sel            <= datai[2:0];
          `FIFO_RD_DELAY:       rd_delay            <= clamp_delay(datai[3:0]);
          `ADC_LOW_RES:         low_res             <= datai[0];
          `FAST_FIFO_READ_MODE: fast_fifo_read_mode <= datai[0];
          `STREAM_SEGMENT_THRESHOLD:
            for (int b = 0; b < pTHRESH_WIDTH; b++)
              if (int'(bytecnt) == b / 8) stream_segment_threshold[b] <= datai[b % 8];
          default: ;
        endcase
      end
    end
  end

  logic clr_all;
  logic clr_sel;
  assign clr_all = wr && (addr == `FIFO_STICKY_ERR) && datai[1];
  assign clr_sel = wr && (addr == `FIFO_STICKY_ERR) && datai[0];

  // New live bits are ORed in after any clear, so a colliding error survives.
  always_ff @(posedge clk_usb or posedge reset_i) begin
    if (reset_i) begin
      for (int n = 0; n < pCHANNELS; n++) sticky[n] <= '0;
    end else begin
      for (int n = 0; n < pCHANNELS; n++) begin
        if (clr_all || (clr_sel && chan_sel == 3'(n))) sticky[n] <= live_pad[n];
        else                                           sticky[n] <= sticky[n] | live_pad[n];
      end
    end
  end

  // A reg_read still high at reset release must not look like a fresh rise:
  // the pipe input stays masked until reg_read has been seen low once.
  logic armed;
  always_ff @(posedge clk_usb or posedge reset_i) begin
    if (reset_i)  armed <= 1'b0;
    else if (!rd) armed <= 1'b1;
  end

  logic        rd_gated;
  logic [15:0] rd_pipe;
  logic [2:0]  rd_tag  [16];
  logic [16:0] rd_ext;
  logic [2:0]  tag_ext [17];

  assign rd_gated = rd & armed;

  always_ff @(posedge clk_usb or posedge reset_i) begin
    if (reset_i) begin
      rd_pipe <= '0;
      for (int k = 0; k < 16; k++) rd_tag[k] <= '0;
    end else begin
      rd_pipe   <= {rd_pipe[14:0], rd_gated};
      rd_tag[0] <= chan_sel;
      for (int k = 1; k < 16; k++) rd_tag[k] <= rd_tag[k-1];
    end
  end

  // Tap 0 is the live request; tap k is the request k cycles ago with its channel.
  assign rd_ext = {rd_pipe, rd_gated};
  always_comb begin
    tag_ext[0] = chan_sel;
    for (int k = 1; k < 17; k++) tag_ext[k] = rd_tag[k-1];
  end

  logic [4:0]           tap;
  logic [4:0]           tap_n;
  logic                 rise_dly;
  logic                 adc_hit;
  logic                 fast_hit;
  logic [pCHANNELS-1:0] strobe_p1;

  assign tap      = {1'b0, rd_delay};
  assign tap_n    = tap + 5'd1;
  assign rise_dly = rd_ext[tap] & ~rd_ext[tap_n];
  assign adc_hit  = (addr == `ADCREAD_ADDR);
  assign fast_hit = rd_gated & ~rd_pipe[0] & adc_hit;

  // Registered strobe stage: one cycle after the delayed rise is seen.
  always_ff @(posedge clk_usb or posedge reset_i) begin
    if (reset_i) strobe_p1 <= '0;
    else         strobe_p1 <= (!fast_fifo_read_mode && rise_dly && adc_hit)
                              ? chan_onehot(tag_ext[tap]) : '0;
  end

  assign fifo_rd_en = fast_fifo_read_mode ? (fast_hit ? chan_onehot(chan_sel) : '0)
                                          : strobe_p1;

`ifdef FIFO_READ_COUNT_EN
  logic [31:0] rd_count;
  always_ff @(posedge clk_usb or posedge reset_i) begin
    if (reset_i)
      rd_count <= '0;
    else if (wr && addr == `DEBUG_FIFO_READS)
      rd_count <= '0;
    else if (|fifo_rd_en && rd_count != 32'hFFFF_FFFF)
      rd_count <= rd_count + 32'd1;
  end
`endif

  logic [63:0] stat_vec;
  logic [63:0] sticky_vec;
  assign stat_vec   = 64'({empty_pad[chan_sel], live_pad[chan_sel]});
  assign sticky_vec = 64'(sticky_pad[chan_sel]);

  always_comb begin
    datao = '0;
    if (rd) begin
      case (addr)
        `FIFO_CHAN_SEL:            datao = {5'b0, chan_sel};
        `FIFO_RD_DELAY:            datao = {4'b0, rd_delay};
        `FIFO_STAT:                datao = get_byte(stat_vec, bytecnt);
        `FIFO_STICKY_ERR:          datao = get_byte(sticky_vec, bytecnt);
        `ADC_LOW_RES:              datao = {7'b0, low_res};
        `STREAM_SEGMENT_THRESHOLD: datao = get_byte(64'(stream_segment_threshold), bytecnt);
        `CAPTURE_DONE:             datao = {7'b0, capture_done};
        `FAST_FIFO_READ_MODE:      datao = {7'b0, fast_fifo_read_mode};
`ifdef FIFO_READ_COUNT_EN
        `DEBUG_FIFO_READS:         datao = get_byte(64'(rd_count), bytecnt);
`endif
        default:                   datao = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_openadc_adcfifo_mc.sv
// Directed bench for reg_openadc_adcfifo_mc (two channels, 9 error bits,
// 17-bit threshold, maximum strobe delay 7).
module tb_reg_openadc_adcfifo_mc;
  localparam logic [7:0] A_ADCREAD = 8'd3;
  localparam logic [7:0] A_THRESH  = 8'd35;
  localparam logic [7:0] A_FAST    = 8'd36;
  localparam logic [7:0] A_CAPDONE = 8'd37;
  localparam logic [7:0] A_LOWRES  = 8'd38;
  localparam logic [7:0] A_STAT    = 8'd39;
  localparam logic [7:0] A_CHSEL   = 8'd40;
  localparam logic [7:0] A_RDDLY   = 8'd41;
  localparam logic [7:0] A_STICKY  = 8'd42;
  localparam logic [7:0] A_COUNT   = 8'd43;
  localparam logic [7:0] A_NONE    = 8'd200;

  logic        clk_usb = 1'b0;
  logic        reset_i;
  logic [1:0]  fifo_empty;
  logic [17:0] fifo_error_stat;
  logic [1:0]  fifo_rd_en;
  logic        capture_done;
  logic        low_res;
  logic        fast_fifo_read_mode;
  logic [16:0] stream_segment_threshold;
  logic        clear_fifo_errors;

  int total = 0;
  int bad   = 0;

  always #5 clk_usb = ~clk_usb;

  reg_openadc_adcfifo_mc_if #(.pBYTECNT_SIZE(7)) bus();

  reg_openadc_adcfifo_mc #(
    .pBYTECNT_SIZE(7), .pCHANNELS(2), .pERR_WIDTH(9),
    .pTHRESH_WIDTH(17), .pMAX_RD_DELAY(7)
  ) dut (
    .clk_usb                  (clk_usb),
    .reset_i                  (reset_i),
    .bus                      (bus),
    .fifo_empty               (fifo_empty),
    .fifo_error_stat          (fifo_error_stat),
    .fifo_rd_en               (fifo_rd_en),
    .capture_done             (capture_done),
    .low_res                  (low_res),
    .fast_fifo_read_mode      (fast_fifo_read_mode),
    .stream_segment_threshold (stream_segment_threshold),
    .clear_fifo_errors        (clear_fifo_errors)
  );

  task automatic idle(input int n);
    repeat (n) @(negedge clk_usb);
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [6:0] b, input logic [7:0] d);
    @(negedge clk_usb);
    bus.reg_address = a; bus.reg_bytecnt = b; bus.reg_datai = d; bus.reg_write = 1'b1;
    @(negedge clk_usb);
    bus.reg_write = 1'b0;
  endtask

  task automatic rd_reg(input logic [7:0] a, input logic [6:0] b, output logic [7:0] d);
    @(negedge clk_usb);
    bus.reg_address = a; bus.reg_bytecnt = b; bus.reg_read = 1'b1;
    #1 d = bus.reg_datao;
    @(negedge clk_usb);
    bus.reg_read = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    reset_i = 1'b1;
    bus.reg_address = '0; bus.reg_bytecnt = '0; bus.reg_datai = '0;
    bus.reg_read = 1'b0; bus.reg_write = 1'b0;
    fifo_empty = '0; fifo_error_stat = '0; capture_done = 1'b0;
    idle(3);
    total++; if (fifo_rd_en !== 2'b00) begin bad++; $display("FAIL rst_rd_en got=%b exp=00", fifo_rd_en); end
    total++; if (low_res !== 1'b0) begin bad++; $display("FAIL rst_low_res got=%b exp=0", low_res); end
    total++; if (fast_fifo_read_mode !== 1'b0) begin bad++; $display("FAIL rst_fast got=%b exp=0", fast_fifo_read_mode); end
    total++; if (clear_fifo_errors !== 1'b0) begin bad++; $display("FAIL rst_clear got=%b exp=0", clear_fifo_errors); end
    total++; if (stream_segment_threshold !== 17'h10000) begin bad++; $display("FAIL rst_thresh got=%h exp=10000", stream_segment_threshold); end
    reset_i = 1'b0;
    idle(2);
    rd_reg(A_THRESH, 7'd0, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL rst_thr_b0 got=%h exp=00", d); end
    rd_reg(A_THRESH, 7'd1, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL rst_thr_b1 got=%h exp=00", d); end
    rd_reg(A_THRESH, 7'd2, d);
    total++; if (d !== 8'h01) begin bad++; $display("FAIL rst_thr_b2 got=%h exp=01", d); end
    rd_reg(A_LOWRES, 7'd0, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL rst_lowres_rd got=%h exp=00", d); end
    rd_reg(A_CHSEL, 7'd0, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL rst_chsel got=%h exp=00", d); end
    rd_reg(A_RDDLY, 7'd0, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL rst_rddly got=%h exp=00", d); end
    total++; if (fifo_rd_en !== 2'b00) begin bad++; $display("FAIL rst_rd_en2 got=%b exp=00", fifo_rd_en); end
  endtask

  task automatic test_registers;
    logic [7:0] d;
    wr_reg(A_LOWRES, 7'd0, 8'h01);
    total++; if (low_res !== 1'b1) begin bad++; $display("FAIL lowres_port got=%b exp=1", low_res); end
    rd_reg(A_LOWRES, 7'd0, d);
    total++; if (d !== 8'h01) begin bad++; $display("FAIL lowres_rd got=%h exp=01", d); end
    capture_done = 1'b1;
    rd_reg(A_CAPDONE, 7'd0, d);
    total++; if (d !== 8'h01) begin bad++; $display("FAIL capdone1 got=%h exp=01", d); end
    capture_done = 1'b0;
    rd_reg(A_CAPDONE, 7'd0, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL capdone0 got=%h exp=00", d); end
    wr_reg(A_THRESH, 7'd0, 8'h34);
    wr_reg(A_THRESH, 7'd1, 8'h12);
    wr_reg(A_THRESH, 7'd2, 8'hFF);
    wr_reg(A_THRESH, 7'd3, 8'hAB);
    total++; if (stream_segment_threshold !== 17'h11234) begin bad++; $display("FAIL thresh_port got=%h exp=11234", stream_segment_threshold); end
    rd_reg(A_THRESH, 7'd2, d);
    total++; if (d !== 8'h01) begin bad++; $display("FAIL thresh_b2 got=%h exp=01", d); end
    rd_reg(A_THRESH, 7'd3, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL thresh_b3 got=%h exp=00", d); end
    wr_reg(A_RDDLY, 7'd0, 8'h0C);
    rd_reg(A_RDDLY, 7'd0, d);
    total++; if (d !== 8'h07) begin bad++; $display("FAIL rddly_clamp got=%h exp=07", d); end
    wr_reg(A_RDDLY, 7'd0, 8'h05);
    rd_reg(A_RDDLY, 7'd0, d);
    total++; if (d !== 8'h05) begin bad++; $display("FAIL rddly_5 got=%h exp=05", d); end
    wr_reg(A_FAST, 7'd0, 8'h01);
    rd_reg(A_NONE, 7'd0, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL unmapped got=%h exp=00", d); end
    @(negedge clk_usb);
    bus.reg_address = A_LOWRES; bus.reg_read = 1'b0;
    #1;
    total++; if (bus.reg_datao !== 8'h00) begin bad++; $display("FAIL datao_idle got=%h exp=00", bus.reg_datao); end
    wr_reg(A_LOWRES, 7'd0, 8'h00);
  endtask

  task automatic test_delayed_strobe;
    int d;
    logic [1:0] exp;
    logic [1:0] one;
    for (int c = 0; c < 2; c++) begin
      d   = (c == 0) ? 3 : 0;
      one = (c == 0) ? 2'b10 : 2'b01;
      wr_reg(A_RDDLY, 7'd0, 8'(d));
      wr_reg(A_CHSEL, 7'd0, (c == 0) ? 8'h01 : 8'h00);
      idle(20);
      @(negedge clk_usb);
      bus.reg_address = A_ADCREAD; bus.reg_read = 1'b1;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk_usb);
        exp = (k == d + 1) ? one : 2'b00;
        total++; if (fifo_rd_en !== exp) begin bad++; $display("FAIL strobe_d%0d_k%0d got=%b exp=%b", d, k, fifo_rd_en, exp); end
      end
      bus.reg_read = 1'b0;
    end
  endtask

  task automatic test_fast_mode;
    logic [7:0] d;
    wr_reg(A_CHSEL, 7'd0, 8'h00);
    wr_reg(A_RDDLY, 7'd0, 8'h03);
    wr_reg(A_FAST, 7'd0, 8'h01);
    rd_reg(A_FAST, 7'd0, d);
    total++; if (d !== 8'h01) begin bad++; $display("FAIL fast_rd got=%h exp=01", d); end
    idle(20);
    @(negedge clk_usb);
    bus.reg_address = A_ADCREAD; bus.reg_read = 1'b1;
    #1;
    total++; if (fifo_rd_en !== 2'b01) begin bad++; $display("FAIL fast_same_cycle got=%b exp=01", fifo_rd_en); end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk_usb);
      total++; if (fifo_rd_en !== 2'b00) begin bad++; $display("FAIL fast_after_k%0d got=%b exp=00", k, fifo_rd_en); end
    end
    bus.reg_read = 1'b0;
    wr_reg(A_LOWRES, 7'd0, 8'h00);
    total++; if (fast_fifo_read_mode !== 1'b0) begin bad++; $display("FAIL fast_cleared_port got=%b exp=0", fast_fifo_read_mode); end
    rd_reg(A_FAST, 7'd0, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL fast_cleared_rd got=%h exp=00", d); end
  endtask

  task automatic test_sticky_errors;
    logic [7:0] d;
    wr_reg(A_CHSEL, 7'd0, 8'h01);
    @(negedge clk_usb); fifo_error_stat[13] = 1'b1;
    @(negedge clk_usb); fifo_error_stat = '0;
    rd_reg(A_STICKY, 7'd0, d);
    total++; if (d !== 8'h10) begin bad++; $display("FAIL sticky_set got=%h exp=10", d); end
    rd_reg(A_STICKY, 7'd1, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL sticky_b1 got=%h exp=00", d); end
    rd_reg(A_STAT, 7'd0, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL live_gone got=%h exp=00", d); end
    wr_reg(A_STICKY, 7'd0, 8'h01);
    rd_reg(A_STICKY, 7'd0, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL sticky_clr got=%h exp=00", d); end
    @(negedge clk_usb);
    fifo_error_stat[13] = 1'b1;
    bus.reg_address = A_STICKY; bus.reg_datai = 8'h01; bus.reg_write = 1'b1;
    @(negedge clk_usb);
    fifo_error_stat = '0; bus.reg_write = 1'b0;
    rd_reg(A_STICKY, 7'd0, d);
    total++; if (d !== 8'h10) begin bad++; $display("FAIL sticky_collide got=%h exp=10", d); end
    wr_reg(A_STICKY, 7'd0, 8'h01);
    @(negedge clk_usb); fifo_error_stat[2] = 1'b1; fifo_error_stat[11] = 1'b1;
    @(negedge clk_usb); fifo_error_stat = '0;
    rd_reg(A_STICKY, 7'd0, d);
    total++; if (d !== 8'h04) begin bad++; $display("FAIL sticky_ch1_bit2 got=%h exp=04", d); end
    wr_reg(A_STICKY, 7'd0, 8'h01);
    rd_reg(A_STICKY, 7'd0, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL sticky_clr_sel got=%h exp=00", d); end
    wr_reg(A_CHSEL, 7'd0, 8'h00);
    rd_reg(A_STICKY, 7'd0, d);
    total++; if (d !== 8'h04) begin bad++; $display("FAIL sticky_other_kept got=%h exp=04", d); end
    @(negedge clk_usb); fifo_error_stat[17] = 1'b1;
    @(negedge clk_usb); fifo_error_stat = '0;
    wr_reg(A_CHSEL, 7'd0, 8'h01);
    rd_reg(A_STICKY, 7'd1, d);
    total++; if (d !== 8'h01) begin bad++; $display("FAIL sticky_ch1_bit8 got=%h exp=01", d); end
    wr_reg(A_STICKY, 7'd0, 8'h02);
    rd_reg(A_STICKY, 7'd1, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL sticky_clrall_ch1 got=%h exp=00", d); end
    wr_reg(A_CHSEL, 7'd0, 8'h00);
    rd_reg(A_STICKY, 7'd0, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL sticky_clrall_ch0 got=%h exp=00", d); end
  endtask

  task automatic test_stat_and_clear;
    logic [7:0] d;
    fifo_empty = 2'b10;
    fifo_error_stat = {9'h1A5, 9'h000};
    wr_reg(A_CHSEL, 7'd0, 8'h01);
    rd_reg(A_STAT, 7'd0, d);
    total++; if (d !== 8'hA5) begin bad++; $display("FAIL stat1_b0 got=%h exp=a5", d); end
    rd_reg(A_STAT, 7'd1, d);
    total++; if (d !== 8'h03) begin bad++; $display("FAIL stat1_b1 got=%h exp=03", d); end
    wr_reg(A_CHSEL, 7'd0, 8'h00);
    rd_reg(A_STAT, 7'd1, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL stat0_b1 got=%h exp=00", d); end
    fifo_empty = 2'b01;
    rd_reg(A_STAT, 7'd1, d);
    total++; if (d !== 8'h02) begin bad++; $display("FAIL stat0_empty got=%h exp=02", d); end
    fifo_empty = 2'b00; fifo_error_stat = '0;
    @(negedge clk_usb);
    bus.reg_address = A_STAT; bus.reg_datai = 8'h01; bus.reg_write = 1'b1;
    #1;
    total++; if (clear_fifo_errors !== 1'b0) begin bad++; $display("FAIL clr_before got=%b exp=0", clear_fifo_errors); end
    @(negedge clk_usb);
    bus.reg_write = 1'b0;
    total++; if (clear_fifo_errors !== 1'b1) begin bad++; $display("FAIL clr_pulse got=%b exp=1", clear_fifo_errors); end
    @(negedge clk_usb);
    total++; if (clear_fifo_errors !== 1'b0) begin bad++; $display("FAIL clr_after got=%b exp=0", clear_fifo_errors); end
    wr_reg(A_STAT, 7'd0, 8'h02);
    total++; if (clear_fifo_errors !== 1'b0) begin bad++; $display("FAIL clr_bit0_zero got=%b exp=0", clear_fifo_errors); end
  endtask

  task automatic test_out_of_range_sel;
    logic [7:0] d;
    wr_reg(A_RDDLY, 7'd0, 8'h00);
    wr_reg(A_CHSEL, 7'd0, 8'h05);
    rd_reg(A_CHSEL, 7'd0, d);
    total++; if (d !== 8'h05) begin bad++; $display("FAIL oor_chsel got=%h exp=05", d); end
    fifo_empty = 2'b11; fifo_error_stat = 18'h3FFFF;
    rd_reg(A_STAT, 7'd0, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL oor_stat_b0 got=%h exp=00", d); end
    rd_reg(A_STAT, 7'd1, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL oor_stat_b1 got=%h exp=00", d); end
    rd_reg(A_STICKY, 7'd0, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL oor_sticky got=%h exp=00", d); end
    fifo_empty = 2'b00; fifo_error_stat = '0;
    idle(20);
    @(negedge clk_usb);
    bus.reg_address = A_ADCREAD; bus.reg_read = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_usb);
      total++; if (fifo_rd_en !== 2'b00) begin bad++; $display("FAIL oor_strobe_k%0d got=%b exp=00", k, fifo_rd_en); end
    end
    bus.reg_read = 1'b0;
    wr_reg(A_FAST, 7'd0, 8'h01);
    idle(3);
    @(negedge clk_usb);
    bus.reg_address = A_ADCREAD; bus.reg_read = 1'b1;
    #1;
    total++; if (fifo_rd_en !== 2'b00) begin bad++; $display("FAIL oor_fast got=%b exp=00", fifo_rd_en); end
    @(negedge clk_usb);
    bus.reg_read = 1'b0;
    wr_reg(A_LOWRES, 7'd0, 8'h00);
  endtask

  task automatic test_chan_sel_change;
    logic [7:0] d;
    logic [1:0] exp;
    wr_reg(A_CHSEL, 7'd0, 8'h00);
    wr_reg(A_RDDLY, 7'd0, 8'h05);
    idle(20);
    @(negedge clk_usb);
    bus.reg_address = A_ADCREAD; bus.reg_read = 1'b1;
    @(negedge clk_usb);
    bus.reg_address = A_CHSEL; bus.reg_datai = 8'h01; bus.reg_write = 1'b1;
    @(negedge clk_usb);
    bus.reg_write = 1'b0; bus.reg_address = A_ADCREAD;
    for (int k = 3; k <= 8; k++) begin
      @(negedge clk_usb);
      exp = (k == 6) ? 2'b01 : 2'b00;
      total++; if (fifo_rd_en !== exp) begin bad++; $display("FAIL tag_k%0d got=%b exp=%b", k, fifo_rd_en, exp); end
    end
    bus.reg_read = 1'b0;
    rd_reg(A_CHSEL, 7'd0, d);
    total++; if (d !== 8'h01) begin bad++; $display("FAIL tag_chsel got=%h exp=01", d); end
  endtask

  task automatic test_back_to_back;
    logic [1:0] exp;
    wr_reg(A_CHSEL, 7'd0, 8'h00);
    wr_reg(A_RDDLY, 7'd0, 8'h02);
    idle(20);
    @(negedge clk_usb);
    bus.reg_address = A_ADCREAD; bus.reg_read = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_usb);
      exp = (k == 3 || k == 6) ? 2'b01 : 2'b00;
      total++; if (fifo_rd_en !== exp) begin bad++; $display("FAIL b2b_k%0d got=%b exp=%b", k, fifo_rd_en, exp); end
      bus.reg_read = (k != 2);
    end
    bus.reg_read = 1'b0;
  endtask

  task automatic test_reset_mid_access;
    logic [7:0] d;
    wr_reg(A_CHSEL, 7'd0, 8'h01);
    wr_reg(A_RDDLY, 7'd0, 8'h05);
    idle(20);
    @(negedge clk_usb);
    bus.reg_address = A_ADCREAD; bus.reg_read = 1'b1;
    @(negedge clk_usb);
    @(negedge clk_usb);
    reset_i = 1'b1;
    #1;
    total++; if (fifo_rd_en !== 2'b00) begin bad++; $display("FAIL midrst_in got=%b exp=00", fifo_rd_en); end
    @(negedge clk_usb);
    reset_i = 1'b0;
    for (int k = 4; k <= 14; k++) begin
      @(negedge clk_usb);
      total++; if (fifo_rd_en !== 2'b00) begin bad++; $display("FAIL midrst_k%0d got=%b exp=00", k, fifo_rd_en); end
    end
    bus.reg_read = 1'b0;
    @(negedge clk_usb);
    bus.reg_read = 1'b1;
    @(negedge clk_usb);
    total++; if (fifo_rd_en !== 2'b01) begin bad++; $display("FAIL midrst_new got=%b exp=01", fifo_rd_en); end
    @(negedge clk_usb);
    total++; if (fifo_rd_en !== 2'b00) begin bad++; $display("FAIL midrst_new_end got=%b exp=00", fifo_rd_en); end
    bus.reg_read = 1'b0;
    rd_reg(A_RDDLY, 7'd0, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL midrst_rddly got=%h exp=00", d); end
  endtask

  task automatic test_read_counter;
    logic [7:0] d;
    idle(20);
`ifdef FIFO_READ_COUNT_EN
    wr_reg(A_COUNT, 7'd0, 8'h00);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_usb);
      bus.reg_address = A_ADCREAD; bus.reg_read = 1'b1;
      @(negedge clk_usb);
      bus.reg_read = 1'b0;
    end
    idle(3);
    rd_reg(A_COUNT, 7'd0, d);
    total++; if (d !== 8'h2C) begin bad++; $display("FAIL cnt_b0 got=%h exp=2c", d); end
    rd_reg(A_COUNT, 7'd1, d);
    total++; if (d !== 8'h01) begin bad++; $display("FAIL cnt_b1 got=%h exp=01", d); end
    rd_reg(A_COUNT, 7'd3, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL cnt_b3 got=%h exp=00", d); end
    @(negedge clk_usb);
    force dut.rd_count = 32'hFFFF_FFFE;
    @(negedge clk_usb);
    release dut.rd_count;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_usb);
      bus.reg_address = A_ADCREAD; bus.reg_read = 1'b1;
      @(negedge clk_usb);
      bus.reg_read = 1'b0;
    end
    idle(3);
    rd_reg(A_COUNT, 7'd0, d);
    total++; if (d !== 8'hFF) begin bad++; $display("FAIL cnt_sat_b0 got=%h exp=ff", d); end
    rd_reg(A_COUNT, 7'd3, d);
    total++; if (d !== 8'hFF) begin bad++; $display("FAIL cnt_sat_b3 got=%h exp=ff", d); end
    wr_reg(A_COUNT, 7'd0, 8'h55);
    rd_reg(A_COUNT, 7'd0, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL cnt_clr got=%h exp=00", d); end
`else
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_usb);
      bus.reg_address = A_ADCREAD; bus.reg_read = 1'b1;
      @(negedge clk_usb);
      bus.reg_read = 1'b0;
    end
    idle(3);
    rd_reg(A_COUNT, 7'd0, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL nocnt_b0 got=%h exp=00", d); end
    rd_reg(A_COUNT, 7'd3, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL nocnt_b3 got=%h exp=00", d); end
`endif
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_registers();
    test_delayed_strobe();
    test_fast_mode();
    test_sticky_errors();
    test_stat_and_clear();
    test_out_of_range_sel();
    test_chan_sel_change();
    test_back_to_back();
    test_reset_mid_access();
    test_read_counter();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_openadc_adcfifo_mc.md
Name: reg_openadc_adcfifo_mc

Overview:
Parametrised multi-channel successor of the OpenADC FIFO register block, on the USB register bus. It serves FIFO status/config registers for pCHANNELS sample FIFOs and generates per-channel FIFO read strobes with a run-time programmable strobe delay, replacing the compile-time slow-board delay. It adds sticky per-channel error capture, a single-cycle error-clear pulse, and an optional saturating read counter.

Parameters:
pBYTECNT_SIZE, 7, width of reg_bytecnt
pCHANNELS, 2, number of FIFOs served (1..8)
pERR_WIDTH, 9, error-status bits per channel
pTHRESH_WIDTH, 17, stream_segment_threshold width (<=32)
pMAX_RD_DELAY, 7, maximum read-strobe delay in clk_usb cycles (<=15)

Ports:
clk_usb  in  1  USB-domain clock
reset_i  in  1  asynchronous active-high reset
reg_address  in  8  register address
reg_bytecnt  in  pBYTECNT_SIZE  byte index within register
reg_datai  in  8  write data
reg_datao  out  8  read data, combinational, 0 when reg_read=0
reg_read  in  1  read flag, level, held for a whole byte access
reg_write  in  1  write flag, one cycle per byte
fifo_empty  in  pCHANNELS  per-channel empty
fifo_error_stat  in  pCHANNELS*pERR_WIDTH  live error bits, channel n at [n*pERR_WIDTH +: pERR_WIDTH]
fifo_rd_en  out  pCHANNELS  per-channel read strobe
capture_done  in  1  capture complete
low_res  out  1  8-bit sample mode
fast_fifo_read_mode  out  1  fast-read mode enable
stream_segment_threshold  out  pTHRESH_WIDTH  streaming segment threshold
clear_fifo_errors  out  1  one-cycle error-clear pulse to the FIFOs

Behaviour:
- Reset (async assert, sync deassert handled upstream): low_res=0, fast_fifo_read_mode=0, stream_segment_threshold=65536 (truncated to width), clear_fifo_errors=0, fifo_rd_en=0, chan_sel=0, rd_delay=0, sticky errors=0, read pipe=0.
- Registers. Addresses are `defines in includes.v.
  - FIFO_CHAN_SEL: RW, 3 bits. Values >= pCHANNELS are written as is, but no strobe is issued for them and status reads return 0.
  - FIFO_RD_DELAY: RW, 4 bits. Written value clamps to pMAX_RD_DELAY.
  - FIFO_STAT: R = {fifo_empty[sel], live err[sel]}, byte-indexed. W: bit0=1 produces clear_fifo_errors high for exactly one cycle after the write.
  - FIFO_STICKY_ERR: R = sticky err[sel], byte-indexed. W: bit0=1 clears sticky[sel]; bit1=1 clears all channels.
  - ADC_LOW_RES: RW, bit0.
  - STREAM_SEGMENT_THRESHOLD: RW, byte-indexed. Bytes beyond the width are ignored.
  - CAPTURE_DONE: R, bit0.
  - FAST_FIFO_READ_MODE: RW, bit0.
  - Unmapped addresses read 0.
- Sticky error: sticky[n] <= sticky[n] | live[n] every cycle. Clear on the same cycle as new live bits: the live bits win (they remain set).
- fast_fifo_read_mode: cleared by any register write to another address.
- Read pipe: 16-bit shift of reg_read each cycle.
  - Rising edge detected at tap rd_delay: pipe[d] & ~pipe[d+1]. With d=0, compare reg_read against pipe[0].
  - Normal mode: when reg_address==ADCREAD_ADDR at the detect cycle, fifo_rd_en[sel] is registered high for one cycle, i.e. latency rd_delay+1 cycles after reg_read rises.
  - Fast mode: fifo_rd_en[sel] = reg_read & ~pipe[0] & (addr==ADCREAD_ADDR), combinational, zero latency; rd_delay is ignored.
  - At most one fifo_rd_en bit is high at any time. No strobe is issued if sel is out of range.
- chan_sel change while a delayed strobe is pending: the strobe goes to the channel captured at reg_read rise. A 3-bit tag travels with the pipe.
- Reset mid-access: the pending strobe is dropped, and no strobe is issued after reset release until a new reg_read rise.

Optional Feature:
FIFO_READ_COUNT_EN.
- Defined: adds FIFO_READ_COUNT (addr `DEBUG_FIFO_READS), a 32-bit counter of fifo_rd_en pulses on any channel. It saturates at 0xFFFFFFFF, reads byte-indexed, and any write clears it. Reset value 0.
- Undefined: no counter logic; the address reads 0.

Test Plan:
1. Reset, then read all registers -> threshold bytes 00,00,01; low_res=0; chan_sel=0; rd_delay=0; fifo_rd_en=0.
2. rd_delay=3, chan_sel=1, reg_read rises at ADCREAD_ADDR on cycle T -> fifo_rd_en=2'b10 only on cycle T+4, for 1 cycle. Write rd_delay=12 with pMAX_RD_DELAY=7 -> reads back 7.
3. fast mode=1, reg_read rises -> fifo_rd_en[0] high same cycle. Then a write to ADC_LOW_RES -> fast mode reads 0.
4. Pulse live err ch1 bit4 for 1 cycle, chan_sel=1 -> FIFO_STICKY_ERR byte0 = 0x10. Write 0x01 -> 0x00. A clear colliding with a live pulse -> bit stays set.
5. Write FIFO_STAT 0x01 -> clear_fifo_errors high exactly 1 cycle. chan_sel=5 with pCHANNELS=2 -> no strobes, FIFO_STAT reads 0.
6. FIFO_READ_COUNT_EN defined: 300 reads -> count reads 0x0000012C. Preload near max -> count holds at 0xFFFFFFFF. Undefined -> the address reads 0.
